// File: rtl/exc_ctrl.sv
// MEM-stage exception/flush sequencer.
// Drives CP0 exception/eret strobes, pipeline flush and fetch redirect.
module exc_ctrl #(
   parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
   parameter int          IDX_W      = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid,
   input  logic [31:0] mem_pc,
   input  logic        mem_bd,
   input  logic        mem_eret,
   input  logic        exc_if_adel,
   input  logic        exc_ri,
   input  logic        exc_ov,
   input  logic        exc_sys,
   input  logic        exc_bp,
   input  logic        exc_adel,
   input  logic        exc_ades,
   input  logic [31:0] mem_addr,
   input  logic        interrupt,
   input  logic [31:0] epc,
   input  logic        dbus_busy,
   input  logic        redirect_ready,
   output logic        cp0_exc,
   output logic [4:0]  cp0_excode,
   output logic [31:0] cp0_badvaddr,
   output logic [31:0] cp0_pc,
   output logic        cp0_bd,
   output logic        cp0_eret_flush,
   output logic        stall_req,
   output logic        flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc
);

   typedef enum logic [IDX_W-1:0] {
      IDLE,
      DRAIN,
      ISSUE,
      REDIRECT
   } state_t;

   state_t      state;

   logic        any_exc;
   logic        evt;

   logic        dec_eret;
   logic [4:0]  dec_code;
   logic [31:0] dec_bva;

   logic        cap_eret;
   logic [4:0]  cap_code;
   logic [31:0] cap_bva;
   logic [31:0] cap_pc;
   logic        cap_bd;

   logic        iss_eret;
   logic [4:0]  iss_code;
   logic [31:0] iss_bva;
   logic [31:0] iss_pc;
   logic        iss_bd;

   assign any_exc = exc_if_adel | exc_ri | exc_ov | exc_sys |
                    exc_bp | exc_adel | exc_ades;
   assign evt     = mem_valid & (interrupt | any_exc | mem_eret);

   // Priority encode the highest-ranked cause; eret only when nothing else.
   always_comb begin
      dec_eret = 1'b0;
      dec_code = 5'h00;
      dec_bva  = 32'h0;
      if (interrupt) begin
         dec_code = 5'h00;
      end else if (exc_if_adel) begin
         dec_code = 5'h04;
         dec_bva  = mem_pc;
      end else if (exc_ri) begin
         dec_code = 5'h0A;
      end else if (exc_ov) begin
         dec_code = 5'h0C;
      end else if (exc_sys) begin
         dec_code = 5'h08;
      end else if (exc_bp) begin
         dec_code = 5'h09;
      end else if (exc_adel) begin
         dec_code = 5'h04;
         dec_bva  = mem_addr;
      end else if (exc_ades) begin
         dec_code = 5'h05;
         dec_bva  = mem_addr;
      end else begin
         dec_eret = 1'b1;
      end
   end

   // Values to publish on ISSUE: live decode when coming straight from
   // IDLE, the frozen capture when coming out of DRAIN.
   always_comb begin
      iss_eret = cap_eret;
      iss_code = cap_code;
      iss_bva  = cap_bva;
      iss_pc   = cap_pc;
      iss_bd   = cap_bd;
      if (state == IDLE) begin
         iss_eret = dec_eret;
         iss_code = dec_code;
         iss_bva  = dec_bva;
         iss_pc   = mem_pc;
         iss_bd   = mem_bd;
      end
   end

   // Stall request: immediate on an event in IDLE, held through DRAIN/ISSUE.
   always_comb begin
      stall_req = 1'b0;
      if (rst) begin
         unique case (state)
            IDLE:     stall_req = evt;
            DRAIN:    stall_req = 1'b1;
            ISSUE:    stall_req = 1'b1;
            REDIRECT: stall_req = 1'b0;
            default:  stall_req = 1'b0;
         endcase
      end
   end

   // Sequencer FSM with registered strobes and data outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= IDLE;
         cap_eret       <= 1'b0;
         cap_code       <= 5'h00;
         cap_bva        <= 32'h0;
         cap_pc         <= 32'h0;
         cap_bd         <= 1'b0;
         cp0_exc        <= 1'b0;
         cp0_eret_flush <= 1'b0;
         cp0_excode     <= 5'h00;
         cp0_badvaddr   <= 32'h0;
         cp0_pc         <= 32'h0;
         cp0_bd         <= 1'b0;
         flush          <= 1'b0;
         redirect_valid <= 1'b0;
         redirect_pc    <= 32'h0;
      end else begin
         cp0_exc        <= 1'b0;
         cp0_eret_flush <= 1'b0;
         unique case (state)
            IDLE: begin
               if (evt) begin
                  cap_eret <= dec_eret;
                  cap_code <= dec_code;
                  cap_bva  <= dec_bva;
                  cap_pc   <= mem_pc;
                  cap_bd   <= mem_bd;
                  if (dbus_busy) begin
                     state <= DRAIN;
                  end else begin
                     state          <= ISSUE;
                     flush          <= 1'b1;
                     cp0_exc        <= ~iss_eret;
                     cp0_eret_flush <= iss_eret;
                     cp0_excode     <= iss_code;
                     cp0_badvaddr   <= iss_bva;
                     cp0_pc         <= iss_pc;
                     cp0_bd         <= iss_bd;
                  end
               end
            end
            DRAIN: begin
               if (!dbus_busy) begin
                  state          <= ISSUE;
                  flush          <= 1'b1;
                  cp0_exc        <= ~iss_eret;
                  cp0_eret_flush <= iss_eret;
                  cp0_excode     <= iss_code;
                  cp0_badvaddr   <= iss_bva;
                  cp0_pc         <= iss_pc;
                  cp0_bd         <= iss_bd;
               end
            end
            ISSUE: begin
               state          <= REDIRECT;
               redirect_valid <= 1'b1;
               redirect_pc    <= cap_eret ? epc : EXC_VECTOR;
            end
            REDIRECT: begin
               if (redirect_ready) begin
                  state          <= IDLE;
                  redirect_valid <= 1'b0;
                  flush          <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_exc_ctrl.sv
// Randomized self-checking bench for exc_ctrl.
// Transaction-level reference model of cause priority and sequencing.
module tb_exc_ctrl;

   localparam logic [31:0] VEC = 32'hBFC00380;

   logic        clk;
   logic        rst;
   logic        mem_valid;
   logic [31:0] mem_pc;
   logic        mem_bd;
   logic        mem_eret;
   logic [6:0]  fl;
   logic [31:0] mem_addr;
   logic        interrupt;
   logic [31:0] epc;
   logic        dbus_busy;
   logic        redirect_ready;
   logic        cp0_exc;
   logic [4:0]  cp0_excode;
   logic [31:0] cp0_badvaddr;
   logic [31:0] cp0_pc;
   logic        cp0_bd;
   logic        cp0_eret_flush;
   logic        stall_req;
   logic        flush;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   int checks = 0;
   int errors = 0;

   logic [4:0]  last_code;
   logic [31:0] last_bva;
   logic [31:0] last_pc;
   logic        last_bd;
   logic [31:0] last_rpc;

   exc_ctrl dut (
      .clk(clk), .rst(rst),
      .mem_valid(mem_valid), .mem_pc(mem_pc),
      .mem_bd(mem_bd), .mem_eret(mem_eret),
      .exc_if_adel(fl[0]), .exc_ri(fl[1]), .exc_ov(fl[2]),
      .exc_sys(fl[3]), .exc_bp(fl[4]), .exc_adel(fl[5]),
      .exc_ades(fl[6]),
      .mem_addr(mem_addr), .interrupt(interrupt), .epc(epc),
      .dbus_busy(dbus_busy), .redirect_ready(redirect_ready),
      .cp0_exc(cp0_exc), .cp0_excode(cp0_excode),
      .cp0_badvaddr(cp0_badvaddr), .cp0_pc(cp0_pc),
      .cp0_bd(cp0_bd), .cp0_eret_flush(cp0_eret_flush),
      .stall_req(stall_req), .flush(flush),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // Cause table in priority order: if_adel, ri, ov, sys, bp, adel, ades.
   function automatic void ref_dec(input logic [6:0] f, input logic intr,
                                   input logic [31:0] pc,
                                   input logic [31:0] addr,
                                   output logic [4:0] code,
                                   output logic [31:0] bva,
                                   output logic is_eret);
      logic [4:0] codes [7];
      codes = '{5'h04, 5'h0A, 5'h0C, 5'h08, 5'h09, 5'h04, 5'h05};
      code    = 5'h00;
      bva     = 32'h0;
      is_eret = 1'b0;
      if (intr) return;
      for (int i = 0; i < 7; i++) begin
         if (f[i]) begin
            code = codes[i];
            if (i == 0) bva = pc;
            else if (i >= 5) bva = addr;
            return;
         end
      end
      is_eret = 1'b1;
   endfunction

   task automatic scramble();
      mem_valid = 1'($urandom);
      fl        = 7'($urandom);
      interrupt = 1'($urandom);
      mem_eret  = 1'($urandom);
      mem_bd    = 1'($urandom);
      mem_pc    = $urandom;
      mem_addr  = $urandom;
      epc       = $urandom;
   endtask

   task automatic chk_zero();
      chk("rst_stall", stall_req, 0);
      chk("rst_exc", cp0_exc, 0);
      chk("rst_eret", cp0_eret_flush, 0);
      chk("rst_flush", flush, 0);
      chk("rst_rv", redirect_valid, 0);
      chk("rst_rpc", redirect_pc, 0);
      chk("rst_pc", cp0_pc, 0);
      chk("rst_bva", cp0_badvaddr, 0);
      chk("rst_code", cp0_excode, 0);
      chk("rst_bd", cp0_bd, 0);
   endtask

   task automatic do_rst();
      #2 rst = 1'b0;
      #1 chk_zero();
      last_code = 0;
      last_bva  = 0;
      last_pc   = 0;
      last_bd   = 0;
      last_rpc  = 0;
      mem_valid = 1'b0;
      dbus_busy = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("post_rst_exc", cp0_exc, 0);
         chk("post_rst_eret", cp0_eret_flush, 0);
         chk("post_rst_flush", flush, 0);
         chk("post_rst_rv", redirect_valid, 0);
      end
   endtask

   task automatic idle_noevt();
      @(posedge clk);
      #1;
      scramble();
      mem_valid = 1'b0;
      interrupt = 1'b1;
      @(negedge clk);
      chk("noevt_stall", stall_req, 0);
      @(posedge clk);
      #1 mem_valid = 1'b0;
      @(negedge clk);
      chk("noevt_exc", cp0_exc, 0);
      chk("noevt_flush", flush, 0);
      chk("noevt_code", cp0_excode, last_code);
   endtask

   task automatic txn(input logic [6:0] f, input logic intr,
                      input logic er, input logic bd,
                      input logic [31:0] pc, input logic [31:0] addr,
                      input logic [31:0] epc_v, input int busy,
                      input int nr, input int rst_at);
      logic [4:0]  xcode;
      logic [31:0] xbva;
      logic        xeret;
      ref_dec(f, intr, pc, addr, xcode, xbva, xeret);
      @(posedge clk);
      #1;
      mem_valid      = 1'b1;
      fl             = f;
      interrupt      = intr;
      mem_eret       = er;
      mem_bd         = bd;
      mem_pc         = pc;
      mem_addr       = addr;
      epc            = $urandom;
      dbus_busy      = (busy > 0);
      redirect_ready = 1'($urandom);
      @(negedge clk);
      chk("evt_stall", stall_req, 1);
      chk("evt_noexc", cp0_exc, 0);
      chk("evt_noflush", flush, 0);
      for (int k = 1; k <= busy; k++) begin
         @(posedge clk);
         #1;
         scramble();
         dbus_busy = (k < busy);
         if (rst_at == 1 && k == 1) begin
            do_rst();
            return;
         end
         @(negedge clk);
         chk("drain_stall", stall_req, 1);
         chk("drain_flush", flush, 0);
         chk("drain_exc", cp0_exc, 0);
         chk("drain_code", cp0_excode, last_code);
         chk("drain_rpc", redirect_pc, last_rpc);
      end
      @(posedge clk);
      #1;
      scramble();
      dbus_busy = 1'($urandom);
      epc       = epc_v;
      @(negedge clk);
      chk("iss_exc", cp0_exc, !xeret);
      chk("iss_eret", cp0_eret_flush, xeret);
      chk("iss_code", cp0_excode, xcode);
      chk("iss_bva", cp0_badvaddr, xbva);
      chk("iss_pc", cp0_pc, pc);
      chk("iss_bd", cp0_bd, bd);
      chk("iss_stall", stall_req, 1);
      chk("iss_flush", flush, 1);
      chk("iss_rv", redirect_valid, 0);
      last_code = xcode;
      last_bva  = xbva;
      last_pc   = pc;
      last_bd   = bd;
      last_rpc  = xeret ? epc_v : VEC;
      for (int j = 0; j <= nr; j++) begin
         @(posedge clk);
         #1;
         scramble();
         redirect_ready = (j == nr);
         if (j == nr) mem_valid = 1'b0;
         if (rst_at == 2 && j == 0) begin
            do_rst();
            return;
         end
         @(negedge clk);
         chk("rd_valid", redirect_valid, 1);
         chk("rd_pc", redirect_pc, last_rpc);
         chk("rd_flush", flush, 1);
         chk("rd_exc", cp0_exc, 0);
         chk("rd_eret", cp0_eret_flush, 0);
         chk("rd_stall", stall_req, 0);
      end
      @(posedge clk);
      #1;
      mem_valid      = 1'b0;
      redirect_ready = 1'($urandom);
      @(negedge clk);
      chk("idle_rv", redirect_valid, 0);
      chk("idle_flush", flush, 0);
      chk("idle_stall", stall_req, 0);
      chk("idle_exc", cp0_exc, 0);
      chk("idle_rpc", redirect_pc, last_rpc);
      chk("idle_pc", cp0_pc, last_pc);
      chk("idle_bva", cp0_badvaddr, last_bva);
      chk("idle_bd", cp0_bd, last_bd);
   endtask

   initial begin
      rst            = 1'b0;
      mem_valid      = 1'b0;
      fl             = '0;
      interrupt      = 1'b0;
      mem_eret       = 1'b0;
      mem_bd         = 1'b0;
      mem_pc         = '0;
      mem_addr       = '0;
      epc            = '0;
      dbus_busy      = 1'b0;
      redirect_ready = 1'b0;
      last_code      = 0;
      last_bva       = 0;
      last_pc        = 0;
      last_bd        = 0;
      last_rpc       = 0;
      repeat (2) @(negedge clk);
      chk_zero();
      @(posedge clk);
      #1 rst = 1'b1;

      // Overflow, no drain, immediate handshake.
      txn(7'b0000100, 0, 0, 0, 32'h80001000, 32'h0,
          32'h0, 0, 0, 0);
      // Store address error while the data bus drains for 3 cycles.
      txn(7'b1000000, 0, 0, 0, 32'h80000040, 32'h80002003,
          32'h0, 3, 0, 0);
      // ERET redirects to EPC.
      txn(7'b0000000, 0, 1, 0, 32'h80000100, 32'h0,
          32'h80000200, 0, 0, 0);
      // Interrupt beats syscall; delay-slot flag carried.
      txn(7'b0001000, 1, 0, 1, 32'h80000300, 32'h0,
          32'h0, 0, 0, 0);
      // Interrupt with no valid instruction is ignored.
      idle_noevt();
      // Fetch holds off the redirect for 4 cycles.
      txn(7'b0010000, 0, 1, 0, 32'h80000400, 32'h0,
          32'h0, 0, 4, 0);
      // Exception beats eret; if_adel reports mem_pc.
      txn(7'b0100001, 0, 1, 0, 32'h80000503, 32'h11,
          32'h0, 1, 1, 0);
      // Reset in DRAIN and in REDIRECT.
      txn(7'b0100000, 0, 0, 0, 32'h80000600, 32'h80000601,
          32'h0, 3, 0, 1);
      txn(7'b0000010, 0, 0, 0, 32'h80000700, 32'h0,
          32'h0, 0, 3, 2);

      for (int n = 0; n < 200; n++) begin
         logic [6:0] f;
         logic       i_;
         logic       e_;
         f  = 7'($urandom & $urandom & $urandom);
         i_ = ($urandom_range(0, 4) == 0);
         e_ = 1'($urandom);
         if (f == 0 && !i_) e_ = 1'b1;
         if ($urandom_range(0, 9) == 0) idle_noevt();
         txn(f, i_, e_, 1'($urandom), $urandom, $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3),
             ($urandom_range(0, 19) == 0) ? $urandom_range(1, 2) : 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception/flush sequencer at the MEM stage of the MIPS pipeline; acts as the driving end of the CP0 exception interface.
- Prioritises per-instruction exception flags and the CP0 interrupt request.
- Drives the CP0 exception/eret update strobes, flushes the pipeline, and redirects fetch to the exception vector or to EPC through a valid/ready handshake.
- Waits for any outstanding data-bus transaction to complete before committing an event.

Parameters:
- EXC_VECTOR, 32'hBFC00380, exception entry address (BEV=1).
- IDX_W, 2, state encoding width.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-low.
- mem_valid  input  1  valid instruction in MEM.
- mem_pc  input  32  PC of MEM instruction.
- mem_bd  input  1  MEM instruction is in a delay slot.
- mem_eret  input  1  MEM instruction is ERET.
- exc_if_adel  input  1  fetch address error.
- exc_ri  input  1  reserved instruction.
- exc_ov  input  1  overflow.
- exc_sys  input  1  syscall.
- exc_bp  input  1  break.
- exc_adel  input  1  data load address error.
- exc_ades  input  1  data store address error.
- mem_addr  input  32  data address.
- interrupt  input  1  pending interrupt from CP0.
- epc  input  32  EPC value from CP0.
- dbus_busy  input  1  data-bus transaction outstanding.
- redirect_ready  input  1  fetch accepts the redirect.
- cp0_exc  output  1  exception strobe to CP0.
- cp0_excode  output  5  exception code.
- cp0_badvaddr  output  32  faulting address.
- cp0_pc  output  32  faulting PC.
- cp0_bd  output  1  delay-slot flag.
- cp0_eret_flush  output  1  eret strobe to CP0.
- stall_req  output  1  freeze IF..MEM.
- flush  output  1  kill IF..MEM contents.
- redirect_valid  output  1  redirect request to fetch.
- redirect_pc  output  32  redirect target.

Behaviour:
- Event detection: `event = mem_valid & (interrupt | any exc_* | mem_eret)`. All of these are ignored when mem_valid=0.
- Priority, highest first, with excode:
  - Int 0x00
  - if_adel 0x04 (badvaddr=mem_pc)
  - RI 0x0A
  - Ov 0x0C
  - Sys 0x08
  - Bp 0x09
  - adel 0x04 (badvaddr=mem_addr)
  - ades 0x05 (badvaddr=mem_addr)
  - eret, lowest (not an exception)
- badvaddr is 0 for every code that does not define it above.
- States: IDLE, DRAIN, ISSUE, REDIRECT.
- IDLE:
  - stall_req = event (combinational).
  - On event, capture kind, code, badvaddr, mem_pc and mem_bd at the clock edge.
  - Next state is DRAIN if dbus_busy=1, else ISSUE.
- DRAIN:
  - stall_req=1.
  - Stay while dbus_busy=1, then go to ISSUE.
  - Captured values are frozen; input changes are ignored.
- ISSUE: lasts exactly one cycle.
  - stall_req=1 and flush=1.
  - Exactly one of cp0_exc or cp0_eret_flush is asserted, according to the captured kind.
  - cp0_excode, cp0_badvaddr, cp0_pc and cp0_bd show the captured values.
  - redirect_pc is loaded with EXC_VECTOR for an exception, or with the epc value sampled in this cycle for an eret.
  - Next state is REDIRECT.
- REDIRECT:
  - redirect_valid=1 and flush=1.
  - redirect_pc is held stable until the handshake.
  - On redirect_valid & redirect_ready, return to IDLE; redirect_valid drops the next cycle.
  - New events are ignored here, because the pipeline is flushed.
- Outputs outside their asserting state:
  - cp0_exc, cp0_eret_flush, flush and redirect_valid are 0.
  - The data outputs hold their last values.
- Latency (dbus_busy=0, redirect_ready=1): event at cycle T, then cp0_exc at T+1, redirect handshake at T+2, IDLE at T+3.
- Simultaneous events:
  - An interrupt together with any exception or eret is taken as Int.
  - An exception together with eret is taken as the exception.
  - When several flags are set, only the highest-priority one is reported.
- Asynchronous reset (rst=0), including mid-sequence:
  - State returns to IDLE.
  - All outputs go to 0, including redirect_pc, cp0_pc, cp0_badvaddr and cp0_excode.
  - No CP0 strobe is issued after reset deasserts.
- Back-to-back events: a new event is accepted in the first IDLE cycle after a REDIRECT handshake.

Test Plan:
- Overflow at mem_pc=0x80001000, dbus_busy=0, redirect_ready=1 -> stall_req at T; cp0_exc=1, excode=0x0C, cp0_pc=0x80001000, flush=1 at T+1; redirect_pc=0xBFC00380 handshake at T+2.
- ades with mem_addr=0x80002003, dbus_busy=1 for 3 cycles -> state held in DRAIN 3 cycles with stall_req=1; then cp0_exc, excode=0x05, badvaddr=0x80002003.
- ERET with epc=0x80000200 -> cp0_eret_flush=1 for one cycle, cp0_exc=0, redirect_pc=0x80000200.
- interrupt=1 together with exc_sys and mem_bd=1 -> excode=0x00, cp0_bd=1; interrupt=1 with mem_valid=0 -> no action.
- redirect_ready low for 4 cycles -> redirect_valid and redirect_pc stable for 4 cycles; IDLE one cycle after ready rises.
- rst asserted in DRAIN and in REDIRECT -> all outputs immediately 0; no cp0_exc pulse after release.
